uart_rx: RTL and testbench

Serial receiver for the board's host UART link: it takes the asynchronous `rxd` pin and delivers framed bytes to the miner's job loader through a one-entry valid/ready buffer. The format is 8N1, LSB first, with idle-high and a fixed baud set by parameter. It is the receive-side counterpart of the existing `txd` path in `Wrapper` and sits between the `rxd` pad and the block-header assembly logic.

---
 rtl/uart_defs.sv | 24 ++
 rtl/sync_2ff.sv | 39 +++
 rtl/uart_rx.sv | 166 ++++++++++++++++
 tb/tb_uart_rx.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_defs.sv
// ---------------------------------------------------------------------------
// uart_defs
// Shared definitions for the host UART link (receiver now, transmitter later).
//   uart_state_e              : receiver FSM state encodings
//   UART_CLKS_PER_BIT_DEFAULT : 100 MHz / 115200 baud
//   half_bit_clks()           : clocks from start-bit edge to mid-bit sample
// ---------------------------------------------------------------------------
package uart_defs;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } uart_state_e;

    localparam int UART_CLKS_PER_BIT_DEFAULT = 868;

    function automatic int half_bit_clks(input int clks_per_bit);
        return clks_per_bit / 2;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// Generic two-flop synchronizer for asynchronous level inputs.
//   WIDTH     : number of independent bits synchronized
//   RESET_VAL : value both flop stages take during reset
// Ports:
//   clk   in   destination clock
//   rst_n in   asynchronous active-low reset
//   d_i   in   asynchronous input
//   q_o   out  synchronized output (two clk edges of latency)
// ---------------------------------------------------------------------------
module sync_2ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // NOTE: sequential state uses non-blocking assignments so both stages
    // update from pre-edge values; blocking here would collapse the chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
// 8N1 serial receiver (LSB first, idle high) with a one-entry valid/ready
// output buffer. Bits are sampled at mid-bit, timed from the falling edge of
// the start bit.
//   CLKS_PER_BIT : clk cycles per bit, must be >= 4
// Ports:
//   clk       in   system clock
//   reset     in   asynchronous active-low reset
//   rxd       in   raw serial line, asynchronous to clk
//   data      out  received byte, stable while valid
//   valid     out  a byte is held in data
//   ready     in   consumer accepts when valid && ready
//   busy      out  a frame is in progress (state != IDLE)
//   frame_err out  one-cycle pulse: stop bit sampled as 0
//   overrun   out  one-cycle pulse: good byte arrived while buffer full
// ---------------------------------------------------------------------------
module uart_rx
    import uart_defs::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun
);

    localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(half_bit_clks(CLKS_PER_BIT) - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic        rx_s;
    uart_state_e state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]  bit_idx_q;
    logic [7:0]  shift_q;
    logic [7:0]  data_q;
    logic        valid_q;
    logic        busy_q;
    logic        frame_err_q;
    logic        overrun_q;

    // Line idles high, so the synchronizer resets to 1 to avoid a false
    // start bit right after reset release.
    sync_2ff #(
        .WIDTH     (1),
        .RESET_VAL (1'b1)
    ) u_sync_rxd (
        .clk   (clk),
        .rst_n (reset),
        .d_i   (rxd),
        .q_o   (rx_s)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            // NOTE: pulse outputs default low every cycle; a later assignment
            // in the case below overrides the default for that cycle only.
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;

            // Handshake drains the buffer; a byte completing this same cycle
            // re-fills it below, since the later assignment wins.
            if (valid_q && ready) begin
                valid_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (!rx_s) begin
                        cnt_q   <= '0;
                        state_q <= ST_START;
                        busy_q  <= 1'b1;
                    end
                end

                // Re-check the start bit at its middle to reject glitches.
                ST_START: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_q <= '0;
                        if (!rx_s) begin
                            state_q <= ST_DATA;
                        end else begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                ST_DATA: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_s, shift_q[7:1]};
                        if (bit_idx_q == 3'd7) begin
                            bit_idx_q <= '0;
                            state_q   <= ST_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                ST_STOP: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q <= '0;
                        if (rx_s) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                            if (!valid_q || ready) begin
                                data_q  <= shift_q;
                                valid_q <= 1'b1;
                            end else begin
                                overrun_q <= 1'b1;
                            end
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= ST_BREAK;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                // Hold here while the line stays low so a break reports once.
                ST_BREAK: begin
                    if (rx_s) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign busy      = busy_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
// Directed frames on rxd; expected bytes go into a queue and a negedge
// monitor pops and compares on every valid && ready transfer. The monitor
// also counts frame_err / overrun pulses and valid rising edges.
// ---------------------------------------------------------------------------
module tb_uart_rx;

    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;
    // Edge offset from E to the stop-bit sample: 2 + HALF + 9*CPB.
    localparam int STOP_OFS = 2 + HALF + 9 * CPB;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       rxd   = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic       busy;
    logic       frame_err;
    logic       overrun;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [7:0] exp_q[$];
    logic [7:0] exp_b;
    int   fe_cnt        = 0;
    int   ov_cnt        = 0;
    int   rise_cnt      = 0;
    int   last_rise_cyc = 0;
    logic valid_prev    = 1'b0;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .reset     (reset),
        .rxd       (rxd),
        .data      (data),
        .valid     (valid),
        .ready     (ready),
        .busy      (busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (reset) begin
            if (valid && ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte: got %0h expected none", data);
                end else begin
                    exp_b = exp_q.pop_front();
                    check("rx_data", {24'd0, data}, {24'd0, exp_b});
                end
            end
            if (frame_err) fe_cnt++;
            if (overrun)   ov_cnt++;
            if (valid && !valid_prev) begin
                rise_cnt++;
                last_rise_cyc = cyc;
            end
        end
        valid_prev = valid;
    end

    // Wait n rising edges, then step just past the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one frame; e returns edge E (first edge that samples start low).
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, output int e);
        e   = cyc + 1;
        rxd = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            tick(CPB);
        end
        rxd = stop_bit;
        tick(CPB);
        rxd = 1'b1;
    endtask

    initial begin
        int e, e2, fe0, ov0, rise0, bcnt;
        logic [7:0] pat;

        // Reset values.
        tick(3);
        check("rst_data", {24'd0, data}, 32'h00);
        check("rst_valid", {31'd0, valid}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_frame_err", {31'd0, frame_err}, 0);
        check("rst_overrun", {31'd0, overrun}, 0);
        reset = 1'b1;
        tick(5);

        // 0xA5 with ready=1: latency and clean flags.
        ready = 1'b1;
        fe0 = fe_cnt; ov0 = ov_cnt; rise0 = rise_cnt;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, e);
        tick(4);
        check_range("a5_valid_latency", last_rise_cyc - e, STOP_OFS, STOP_OFS + 2);
        check("a5_valid_rises", rise_cnt - rise0, 1);
        check("a5_frame_err", fe_cnt - fe0, 0);
        check("a5_overrun", ov_cnt - ov0, 0);

        // 0x00 then 0xFF back-to-back with ready=0: overrun, old byte kept.
        ready = 1'b0;
        fe0 = fe_cnt; ov0 = ov_cnt; rise0 = rise_cnt;
        exp_q.push_back(8'h00);
        send_frame(8'h00, 1'b1, e);
        send_frame(8'hFF, 1'b1, e);
        tick(4);
        check("ovr_pulses", ov_cnt - ov0, 1);
        check("ovr_frame_err", fe_cnt - fe0, 0);
        check("ovr_data_held", {24'd0, data}, 32'h00);
        check("ovr_valid_held", {31'd0, valid}, 1);
        check("ovr_valid_rises", rise_cnt - rise0, 1);
        ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("ovr_valid_falls", {31'd0, valid}, 0);
        @(posedge clk);
        #1;

        // Handshake on the same edge a new byte (0x7E) completes.
        ready = 1'b0;
        ov0 = ov_cnt; rise0 = rise_cnt;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, e);
        tick(2);
        exp_q.push_back(8'h7E);
        fork
            send_frame(8'h7E, 1'b1, e2);
            begin
                repeat (STOP_OFS) @(posedge clk);
                #1;
                ready = 1'b1;
                @(posedge clk);
                #1;
                ready = 1'b0;
            end
        join
        tick(2);
        check("same_cycle_overrun", ov_cnt - ov0, 0);
        check("same_cycle_valid", {31'd0, valid}, 1);
        check("same_cycle_data", {24'd0, data}, 32'h7E);
        check("same_cycle_rises", rise_cnt - rise0, 1);
        ready = 1'b1;
        tick(3);
        check("same_cycle_drained", {31'd0, valid}, 0);

        // 0x3C with stop bit 0, line held low ~40 bit times: one frame_err.
        fe0 = fe_cnt; rise0 = rise_cnt;
        pat = 8'h3C;
        rxd = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rxd = pat[i];
            tick(CPB);
        end
        rxd = 1'b0;
        tick(41 * CPB);
        @(negedge clk);
        check("break_busy_held", {31'd0, busy}, 1);
        @(posedge clk);
        #1;
        rxd = 1'b1;
        tick(6);
        check("break_busy_released", {31'd0, busy}, 0);
        check("break_frame_err", fe_cnt - fe0, 1);
        check("break_no_valid", rise_cnt - rise0, 0);

        // 5-cycle glitch on idle line.
        fe0 = fe_cnt; rise0 = rise_cnt;
        rxd = 1'b0;
        tick(5);
        rxd = 1'b1;
        bcnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy) bcnt++;
        end
        @(posedge clk);
        #1;
        check_range("glitch_busy_cycles", bcnt, 1, HALF + 3);
        check("glitch_busy_idle", {31'd0, busy}, 0);
        check("glitch_frame_err", fe_cnt - fe0, 0);
        check("glitch_no_valid", rise_cnt - rise0, 0);

        // Reset during bit 4 of 0x5A, then receive 0x81 only.
        pat = 8'h5A;
        rxd = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) begin
            rxd = pat[i];
            tick(CPB);
        end
        rxd = pat[4];
        tick(HALF);
        reset = 1'b0;
        tick(2);
        check("midrst_data", {24'd0, data}, 32'h00);
        check("midrst_valid", {31'd0, valid}, 0);
        check("midrst_busy", {31'd0, busy}, 0);
        check("midrst_frame_err", {31'd0, frame_err}, 0);
        check("midrst_overrun", {31'd0, overrun}, 0);
        rxd = 1'b1;
        tick(2);
        reset = 1'b1;
        tick(10);
        rise0 = rise_cnt;
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1, e);
        tick(6);
        check("postrst_one_byte", rise_cnt - rise0, 1);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
